pixel_fetch: RTL and testbench

- Downstream stage of syncgen. Consumes PCK, HS, VS, HCNT, VCNT and ENABLE_MEM, reads per-pixel Julia iteration counts from the frame buffer, and maps each count to 12-bit VGA colour.
- HS and VS are delayed to stay aligned with the colour pipeline.
- All logic runs on the 125 MHz CLK. PCK is treated as a sampled level, not as a clock.

---
 rtl/pixel_fetch_if.sv | 31 +++
 rtl/pixel_fetch.sv | 90 +++++++++
 tb/tb_pixel_fetch.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_fetch_if.sv
// pixel_fetch_if: syncgen timing inputs, frame buffer read bus and VGA outputs of pixel_fetch.
// PIXEL_FETCH_PALETTE_RAM_EN adds the palette write port.
interface pixel_fetch_if #(parameter int ADDR_W = 19);
   logic PCK, HS_IN, VS_IN, ENABLE_MEM, MEM_RD, VGA_HS, VGA_VS, FRAME_DONE, UNDERRUN;
   logic [9:0] HCNT, VCNT;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [7:0] MEM_RDATA;
   logic [3:0] VGA_R, VGA_G, VGA_B;
`ifdef PIXEL_FETCH_PALETTE_RAM_EN
   logic PAL_WE;
   logic [7:0] PAL_WADDR;
   logic [11:0] PAL_WDATA;
   modport master (
      input PCK, HS_IN, VS_IN, HCNT, VCNT, ENABLE_MEM, MEM_RDATA, PAL_WE, PAL_WADDR, PAL_WDATA,
      output MEM_ADDR, MEM_RD, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, FRAME_DONE, UNDERRUN
   );
   modport slave (
      output PCK, HS_IN, VS_IN, HCNT, VCNT, ENABLE_MEM, MEM_RDATA, PAL_WE, PAL_WADDR, PAL_WDATA,
      input MEM_ADDR, MEM_RD, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, FRAME_DONE, UNDERRUN
   );
`else
   modport master (
      input PCK, HS_IN, VS_IN, HCNT, VCNT, ENABLE_MEM, MEM_RDATA,
      output MEM_ADDR, MEM_RD, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, FRAME_DONE, UNDERRUN
   );
   modport slave (
      output PCK, HS_IN, VS_IN, HCNT, VCNT, ENABLE_MEM, MEM_RDATA,
      input MEM_ADDR, MEM_RD, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, FRAME_DONE, UNDERRUN
   );
`endif
endinterface

// File: rtl/pixel_fetch.sv
// pixel_fetch: per-pixel frame buffer fetch of Julia iteration counts mapped to 12-bit VGA colour.
// Define PIXEL_FETCH_PALETTE_RAM_EN to replace the fixed colour formula with a writable 256x12 palette.
module pixel_fetch #(
   parameter int ADDR_W = 19,
   parameter int FRAME_WORDS = 307200,
   parameter logic [7:0] MAX_ITER = 8'hFF,
   parameter logic SYNC_POL = 1'b0
) (
   input logic CLK,
   input logic RST,
   pixel_fetch_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPT} state_t;
   state_t state, state_nx;
   logic pck_d, vs_d, tick, vs_edge, armed, busy, wait_cnt, pend_blank, frame_done, underrun, last;
   logic [7:0] iter_q, iter_cur;
   logic [ADDR_W-1:0] addr;
   logic [1:0] hs_sr, vs_sr;
   logic [11:0] rgb, rgb_nx, hue;

   assign tick = bus.PCK & ~pck_d;
   assign vs_edge = (bus.VS_IN == SYNC_POL) && (vs_d != SYNC_POL);
   assign busy = (state == REQ) || (state == WAIT);
   assign last = addr == ADDR_W'(FRAME_WORDS - 1);
   // a tick landing in CAPT must already see the word captured in that cycle
   assign iter_cur = (state == CAPT) ? bus.MEM_RDATA : iter_q;

`ifdef PIXEL_FETCH_PALETTE_RAM_EN
   logic [11:0] pal [256];
   assign hue = pal[iter_cur];
   always_ff @(posedge CLK)
      if (!RST) for (int i = 0; i < 256; i++) pal[i] <= '0;
      else if (bus.PAL_WE) pal[bus.PAL_WADDR] <= bus.PAL_WDATA;
`else
   assign hue = (iter_cur == MAX_ITER) ? 12'h000 : {iter_cur[7:4], iter_cur[5:2], ~iter_cur[3:0]};
`endif

   always_comb begin
      state_nx = state;
      rgb_nx = (busy || pend_blank) ? 12'h000 : hue;
      if (state == REQ) state_nx = WAIT;
      else if (state == WAIT && wait_cnt) state_nx = CAPT;
      else if (!busy) state_nx = tick ? REQ : IDLE;
   end

   always_ff @(posedge CLK) begin
      pck_d <= bus.PCK;
      vs_d <= bus.VS_IN;
      if (!RST) begin
         state <= IDLE;
         wait_cnt <= 1'b0;
         armed <= 1'b0;
         pend_blank <= 1'b1;
         iter_q <= '0;
         addr <= '0;
         frame_done <= 1'b0;
         underrun <= 1'b0;
         hs_sr <= {2{~SYNC_POL}};
         vs_sr <= {2{~SYNC_POL}};
         rgb <= '0;
      end else begin
         state <= state_nx;
         wait_cnt <= (state == WAIT) && !wait_cnt;
         armed <= armed | vs_edge;
         addr <= vs_edge ? '0 : bus.MEM_RD ? (last ? '0 : addr + 1'b1) : addr;
         frame_done <= bus.MEM_RD & last;
         if (state == CAPT) iter_q <= bus.MEM_RDATA;
         if (tick) begin
            rgb <= rgb_nx;
            hs_sr <= {hs_sr[0], bus.HS_IN};
            vs_sr <= {vs_sr[0], bus.VS_IN};
            // a tick during an unfinished fetch cannot start a read, so its pixel is blank
            pend_blank <= busy | ~(bus.ENABLE_MEM & (armed | vs_edge));
            underrun <= underrun | busy;
         end
      end
   end

   // syncgen only enables fetching inside the 640x480 active area
   always_ff @(posedge CLK)
      if (RST && tick && bus.ENABLE_MEM) assert (bus.HCNT < 10'd640 && bus.VCNT < 10'd480);

   assign bus.MEM_RD = (state == REQ) && !pend_blank;
   assign bus.MEM_ADDR = addr;
   assign {bus.VGA_R, bus.VGA_G, bus.VGA_B} = rgb;
   assign bus.VGA_HS = hs_sr[1];
   assign bus.VGA_VS = vs_sr[1];
   assign bus.FRAME_DONE = frame_done;
   assign bus.UNDERRUN = underrun;
endmodule

// File: tb/tb_pixel_fetch.sv
// tb_pixel_fetch: random pixel stream against a tick-level reference model, scoreboard-checked.
`timescale 1ns/1ps
module tb_pixel_fetch;
   localparam int ADDR_W = 19;
   localparam int FW = 600;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   pixel_fetch_if #(.ADDR_W(ADDR_W)) bus ();
   pixel_fetch #(.ADDR_W(ADDR_W), .FRAME_WORDS(FW), .MAX_ITER(8'hFF), .SYNC_POL(1'b0))
      dut (.CLK(CLK), .RST(RST), .bus(bus));

   int checks = 0, errors = 0, fd_cnt = 0, exp_frames = 0;
   logic [13:0] exp_q [$];
   int addr_q [$];
   bit chk_on = 0, rd_chk = 1;
   int m_addr;
   bit m_armed, m_blank, m_hs, m_vs, m_vsin;
   logic [7:0] m_iter;
`ifdef PIXEL_FETCH_PALETTE_RAM_EN
   logic [11:0] pal_m [256];
`endif

   // frame buffer: word at address a holds a[7:0], returned two clocks after the strobe and held
   logic rd_d;
   logic [ADDR_W-1:0] ad_d;
   initial bus.MEM_RDATA = 8'h00;
   always @(posedge CLK) begin
      rd_d <= bus.MEM_RD;
      ad_d <= bus.MEM_ADDR;
      if (rd_d) bus.MEM_RDATA <= ad_d[7:0];
   end

   function automatic logic [11:0] colour(logic [7:0] it);
`ifdef PIXEL_FETCH_PALETTE_RAM_EN
      return pal_m[it];
`else
      return (it == 8'hFF) ? 12'h000 : {it[7:4], it[5:2], ~it[3:0]};
`endif
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_addr = 0;
      m_armed = 0;
      m_blank = 1;
      m_iter = 8'h00;
      m_hs = 1;
      m_vs = 1;
      m_vsin = bus.VS_IN;
`ifdef PIXEL_FETCH_PALETTE_RAM_EN
      for (int i = 0; i < 256; i++) pal_m[i] = 12'h000;
`endif
   endtask

   // one pixel: output shows the previous pixel; this pixel reads the next frame word if enabled
   task automatic model(bit en, bit hs, bit vs);
      exp_q.push_back({m_blank ? 12'h000 : colour(m_iter), m_hs, m_vs});
      if (!vs && m_vsin) begin
         m_armed = 1;
         m_addr = 0;
      end
      m_vsin = vs;
      m_hs = hs;
      m_vs = vs;
      m_blank = !(en && m_armed);
      if (!m_blank) begin
         m_iter = 8'(m_addr);
         addr_q.push_back(m_addr);
         if (m_addr == FW - 1) begin
            m_addr = 0;
            exp_frames++;
         end else m_addr++;
      end
   endtask

   task automatic pix(int per, bit en, bit hs, bit vs);
      @(negedge CLK);
      bus.PCK = 1;
      bus.ENABLE_MEM = en;
      bus.HS_IN = hs;
      bus.VS_IN = vs;
      if (RST && chk_on) model(en, hs, vs);
      repeat (per / 2) @(negedge CLK);
      bus.PCK = 0;
      repeat (per - per / 2 - 1) @(negedge CLK);
   endtask

   initial begin : pixel_monitor
      logic lp;
      logic [13:0] got, e;
      lp = 0;
      forever begin
         @(posedge CLK);
         if (bus.PCK && !lp && RST && chk_on) begin
            #1;
            got = {bus.VGA_R, bus.VGA_G, bus.VGA_B, bus.VGA_HS, bus.VGA_VS};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pixel: got rgb=%h hs=%b vs=%b, required an expected entry", got[13:2], got[1], got[0]);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL pixel: got rgb=%h hs=%b vs=%b, required rgb=%h hs=%b vs=%b",
                           got[13:2], got[1], got[0], e[13:2], e[1], e[0]);
               end
            end
         end
         lp = bus.PCK;
      end
   end

   always @(negedge CLK) begin
      if (bus.MEM_RD === 1'b1 && rd_chk) begin
         checks++;
         if (addr_q.size() == 0) begin
            errors++;
            $display("FAIL mem_rd: got read of addr %0d, required no read", bus.MEM_ADDR);
         end else if (int'(bus.MEM_ADDR) != addr_q[0]) begin
            errors++;
            $display("FAIL mem_addr: got %0d, required %0d", bus.MEM_ADDR, addr_q.pop_front());
         end else void'(addr_q.pop_front());
      end
      if (bus.FRAME_DONE === 1'b1) begin
         fd_cnt++;
         chk("wrap_addr", 32'(bus.MEM_ADDR), 0);
      end
   end

   initial begin
      bit hs;
      hs = 1;
      bus.PCK = 0;
      bus.HS_IN = 1;
      bus.VS_IN = 1;
      bus.ENABLE_MEM = 0;
      bus.HCNT = '0;
      bus.VCNT = '0;
`ifdef PIXEL_FETCH_PALETTE_RAM_EN
      bus.PAL_WE = 0;
      bus.PAL_WADDR = '0;
      bus.PAL_WDATA = '0;
`endif
      repeat (25) pix(4, 1, 1'($urandom_range(0, 1)), 1);
      chk("rst_rgb", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, 0);
      chk("rst_hs", bus.VGA_HS, 1);
      chk("rst_vs", bus.VGA_VS, 1);
      chk("rst_addr", 32'(bus.MEM_ADDR), 0);
      chk("rst_rd", bus.MEM_RD, 0);
      chk("rst_done", bus.FRAME_DONE, 0);
      chk("rst_underrun", bus.UNDERRUN, 0);
      @(negedge CLK) RST = 1;
      model_reset();
`ifdef PIXEL_FETCH_PALETTE_RAM_EN
      for (int i = 0; i < 256; i++) begin
         @(negedge CLK);
         bus.PAL_WE = 1;
         bus.PAL_WADDR = 8'(i);
         bus.PAL_WDATA = (i == 16) ? 12'hABC : 12'($urandom);
         pal_m[i] = bus.PAL_WDATA;
      end
      @(negedge CLK) bus.PAL_WE = 0;
`endif
      chk_on = 1;
      repeat (6) pix(4, 1, 1, 1);
      for (int i = 0; i < 1300; i++) begin
         if ($urandom_range(0, 15) == 0) hs = ~hs;
         pix($urandom_range(4, 7), $urandom_range(0, 7) != 0, hs, !(i < 3 || (i >= 900 && i < 903)));
      end
      repeat (8) @(negedge CLK);
      chk("reads_pending", addr_q.size(), 0);
      chk("frame_done_count", fd_cnt, exp_frames);
      chk("underrun_normal", bus.UNDERRUN, 0);
      chk_on = 0;
      rd_chk = 0;
      repeat (20) pix(2, 1, 1, 1);
      chk("underrun_set", bus.UNDERRUN, 1);
      chk("underrun_blank", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, 0);
      repeat (5) pix(5, 1, 1, 1);
      chk("underrun_sticky", bus.UNDERRUN, 1);
      @(negedge CLK);
      bus.PCK = 1;
      RST = 0;
      repeat (3) @(negedge CLK);
      chk("midrst_underrun", bus.UNDERRUN, 0);
      chk("midrst_addr", 32'(bus.MEM_ADDR), 0);
      chk("midrst_rgb", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, 0);
      bus.PCK = 0;
      RST = 1;
      model_reset();
      addr_q.delete();
      exp_q.delete();
      rd_chk = 1;
      chk_on = 1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0) hs = ~hs;
         pix($urandom_range(4, 6), 1, hs, !(i >= 10 && i < 12));
      end
      repeat (8) @(negedge CLK);
      chk("reads_pending_end", addr_q.size(), 0);
      chk("frame_done_total", fd_cnt, exp_frames);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
